dht22_responder: RTL
====================

// Module: dht22_responder
// PURPOSE
//  Emulates a DHT22 sensor on the single-wire bus, as the responder end of the LeitorDHT22 host.
//  Detects the host start pulse, answers with the 80/80 us preamble, then a 40-bit frame:
//  umid[15:0], temp[15:0], checksum[7:0], MSB first. Used as a bench model and as a
//  board-level stand-in when no sensor is fitted. Drives the line open-drain: low or Z only.
// PARAMETERS
//  CLK_FREQ_HZ   100000000  system clock; one 1 us tick every CLK_FREQ_HZ/1000000 cycles
//  START_MIN_US  800        minimum host low time accepted as a start pulse
//  RESP_DELAY_US 30         delay from host release to the responder pulling the line low
//  HOLDOFF_MS    10         time after a frame ends during which start pulses are ignored
// PORTS
//  clk              in     1   system clock
//  reset_n          in     1   asynchronous reset, active low
//  dht_pin          inout  1   bus line: 1'b0 when driving, else 1'bz (external pull-up)
//  umidade          in     16  humidity x10; sampled on host release
//  temperatura      in     16  bit15 = sign, [14:0] = |T| x10; sampled on host release
//  ocupado          out    1   high from start-pulse acceptance to the end of holdoff
//  quadro_enviado   out    1   1-cycle pulse when the final bit's low phase ends
//  erro_colisao     out    1   1-cycle pulse on bus contention abort
//  estado_depuracao out    4   current FSM state encoding
// BEHAVIOUR
//  Reset: line released (Z) combinationally. All outputs 0. FSM = IDLE. Counters cleared.
//  Input path: dht_pin passes through a 2-FF synchronizer (2-cycle latency) before any use.
//  Timing: all phases are counted in 1 us ticks from tick_us_gen. Each phase is exact to +/-1 tick.
//  FSM:
//   IDLE       : sync line low -> START_LOW, clear the us counter.
//   START_LOW  : count us while low; set armed at START_MIN_US.
//                On rise: armed -> latch frame, go to RESP_DELAY. Not armed -> IDLE (glitch ignored).
//   RESP_DELAY : RESP_DELAY_US released -> RESP_LOW.
//   RESP_LOW   : drive 80 us -> RESP_HIGH.
//   RESP_HIGH  : release 80 us -> BIT_LOW, bit index = 39.
//   BIT_LOW    : drive 50 us -> BIT_HIGH.
//   BIT_HIGH   : release 26 us for bit 0, 70 us for bit 1.
//                Index > 0 -> decrement, go to BIT_LOW. Index = 0 -> END_LOW.
//   END_LOW    : drive 50 us, pulse quadro_enviado -> HOLDOFF.
//   HOLDOFF    : release HOLDOFF_MS; line activity ignored -> IDLE.
//  Frame latch: shift reg <= {umidade, temperatura, cks}.
//   cks = (umid[15:8]+umid[7:0]+temp[15:8]+temp[7:0]) mod 256.
//   Inputs changing after the latch do not affect the frame in flight.
//  Contention check: sample the sync line at the last tick of RESP_HIGH and of every BIT_HIGH.
//   Line low there -> release, pulse erro_colisao, go to HOLDOFF.
//  A host holding low longer than START_MIN_US is still a valid start; the response begins on release.
//  ocupado = 1 in every state except IDLE and START_LOW.
//  Reset mid-frame: line released at once. The partial frame is discarded; no pulse outputs.
// CONFIGURATION
//  `DHT_RESP_FAULT_INJ_EN defined:
//   - adds input port falha_checksum (1 bit), sampled together with the frame.
//   - when 1, checksum bit0 is inverted in the transmitted frame.
//  Macro undefined: the port is absent and the checksum is always correct.
// STRUCTURE
//  Shared header dht22_defs.vh, also included by LeitorDHT22:
//   protocol constants T_RESP_LOW_US=80, T_RESP_HIGH_US=80, T_BIT_LOW_US=50,
//   T_BIT0_HIGH_US=26, T_BIT1_HIGH_US=70, T_END_LOW_US=50, FRAME_BITS=40;
//   responder state encodings.
//  Sub-module tick_us_gen(clk, reset_n, tick): 1-cycle pulse every CLK_FREQ_HZ/1e6 cycles.
// TESTING
//  1 umid=16'h028C, temp=16'h0115, 1 ms start pulse ->
//    preamble 80/80 us, bits decode to 028C_0115_A4, one quadro_enviado pulse.
//  2 umid=16'h01F4, temp=16'h8065 ->
//    frame 01F4_8065_DA; bit 16 (temp sign bit) high for 70 us.
//  3 500 us low pulse -> line never driven, ocupado stays 0, FSM back in IDLE.
//  4 reset_n asserted during bit 20 ->
//    line Z in the same cycle; no quadro_enviado; the next 1 ms start gives a full, correct frame.
//  5 bench holds the line low through a BIT_HIGH phase ->
//    erro_colisao pulse, line released, HOLDOFF entered.
//  6 second start pulse 5 ms after frame end -> ignored; at 15 ms -> answered.
//  7 loopback with LeitorDHT22 on a pulled-up wire, `DHT_RESP_FAULT_INJ_EN defined ->
//    falha_checksum=0: dados_prontos=1, checksum_ok=1, values match.
//    falha_checksum=1: checksum_ok=0.

Source files
------------

// File: rtl/dht22_responder_pkg.sv
// Shared definitions for the DHT22 responder.
// Holds the single-wire protocol timing constants (in microseconds), the frame
// length, the responder FSM state encoding (also visible on estado_depuracao)
// and the checksum helper used when the frame is latched.
package dht22_responder_pkg;

    localparam int unsigned T_RESP_LOW_US  = 80;
    localparam int unsigned T_RESP_HIGH_US = 80;
    localparam int unsigned T_BIT_LOW_US   = 50;
    localparam int unsigned T_BIT0_HIGH_US = 26;
    localparam int unsigned T_BIT1_HIGH_US = 70;
    localparam int unsigned T_END_LOW_US   = 50;
    localparam int unsigned FRAME_BITS     = 40;

    typedef enum logic [3:0] {
        StIdle      = 4'd0,
        StStartLow  = 4'd1,
        StRespDelay = 4'd2,
        StRespLow   = 4'd3,
        StRespHigh  = 4'd4,
        StBitLow    = 4'd5,
        StBitHigh   = 4'd6,
        StEndLow    = 4'd7,
        StHoldoff   = 4'd8
    } state_e;

    // Byte-wise sum of the four data bytes, wrapping modulo 256.
    function automatic logic [7:0] frame_checksum(input logic [15:0] umid,
                                                  input logic [15:0] temp);
        return umid[15:8] + umid[7:0] + temp[15:8] + temp[7:0];
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dht22_responder_tick_us_gen.sv
// Microsecond tick generator.
// Emits a one-cycle pulse on tick every CLK_FREQ_HZ/1e6 clock cycles; with a
// divider of 1 (or less) the tick is permanently high.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous reset, active low
//   tick     out  1-cycle pulse once per microsecond
module dht22_responder_tick_us_gen #(
    parameter int unsigned CLK_FREQ_HZ = 100000000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int unsigned Div  = (CLK_FREQ_HZ / 1000000 > 1) ? CLK_FREQ_HZ / 1000000 : 1;
    localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign tick = (cnt_q == CntW'(Div - 1));

endmodule

// File: rtl/dht22_responder.sv
// DHT22 sensor emulator (responder end of the single-wire bus).
// Detects a host start pulse, answers with the 80/80 us preamble and sends a
// 40-bit frame {umidade, temperatura, checksum} MSB first. The line is only
// ever pulled low or released (open drain, external pull-up).
// Optional feature macro: DHT_RESP_FAULT_INJ_EN adds input falha_checksum,
// which inverts bit 0 of the transmitted checksum when set at latch time.
// Ports:
//   clk              in     system clock
//   reset_n          in     asynchronous reset, active low
//   dht_pin          inout  bus line, 0 when driving, Z otherwise
//   umidade          in     humidity x10, latched on host release
//   temperatura      in     sign + |T| x10, latched on host release
//   ocupado          out    high outside IDLE/START_LOW
//   quadro_enviado   out    1-cycle pulse when the final low phase ends
//   erro_colisao     out    1-cycle pulse when contention aborts a frame
//   estado_depuracao out    current FSM state
//   falha_checksum   in     (DHT_RESP_FAULT_INJ_EN only) corrupt checksum bit 0
module dht22_responder
    import dht22_responder_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ   = 100000000,
    parameter int unsigned START_MIN_US  = 800,
    parameter int unsigned RESP_DELAY_US = 30,
    parameter int unsigned HOLDOFF_MS    = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    inout  wire         dht_pin,
    input  logic [15:0] umidade,
    input  logic [15:0] temperatura,
    output logic        ocupado,
    output logic        quadro_enviado,
    output logic        erro_colisao,
    output logic [3:0]  estado_depuracao
`ifdef DHT_RESP_FAULT_INJ_EN
    ,
    input  logic        falha_checksum
`endif
);

    localparam int unsigned HoldoffUs = HOLDOFF_MS * 1000;
    localparam int unsigned MaxUs     = max_u(max_u(START_MIN_US, HoldoffUs),
                                              max_u(RESP_DELAY_US, T_RESP_LOW_US));
    localparam int unsigned CntW      = $clog2(MaxUs + 1);
    localparam int unsigned IdxW      = $clog2(FRAME_BITS);
    localparam logic [CntW-1:0] CntSat = '1;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  armed_q, armed_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic                  sent_q, sent_d;
    logic                  err_q, err_d;
    logic [1:0]            sync_q;

    logic                  tick;
    logic                  line;
    logic                  drive_low;
    logic                  phase_done;
    int unsigned           phase_us;
    logic [7:0]            cks_tx;
    logic [FRAME_BITS-1:0] frame_in;

    dht22_responder_tick_us_gen #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick)
    );

`ifdef DHT_RESP_FAULT_INJ_EN
    assign cks_tx = frame_checksum(umidade, temperatura) ^ {7'b0, falha_checksum};
`else
    assign cks_tx = frame_checksum(umidade, temperatura);
`endif

    assign frame_in = {umidade, temperatura, cks_tx};
    assign line     = sync_q[1];

    // State register; the synchronizer resets high so reset never looks like a start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            idx_q   <= '0;
            frame_q <= '0;
            sent_q  <= 1'b0;
            err_q   <= 1'b0;
            sync_q  <= 2'b11;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            sent_q  <= sent_d;
            err_q   <= err_d;
            sync_q  <= {sync_q[0], dht_pin};
        end
    end

    // Length of the current phase; in START_LOW it is the arming threshold.
    always_comb begin
        phase_us = START_MIN_US;
        unique case (state_q)
            StRespDelay: phase_us = RESP_DELAY_US;
            StRespLow:   phase_us = T_RESP_LOW_US;
            StRespHigh:  phase_us = T_RESP_HIGH_US;
            StBitLow:    phase_us = T_BIT_LOW_US;
            StBitHigh:   phase_us = frame_q[FRAME_BITS-1] ? T_BIT1_HIGH_US : T_BIT0_HIGH_US;
            StEndLow:    phase_us = T_END_LOW_US;
            StHoldoff:   phase_us = HoldoffUs;
            default:     phase_us = START_MIN_US;
        endcase
    end

    assign phase_done = tick && (cnt_q == CntW'(phase_us - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        sent_d  = 1'b0;
        err_d   = 1'b0;

        // Saturate so a host holding the line very long cannot wrap the counter.
        if (tick && (cnt_q != CntSat)) begin
            cnt_d = cnt_q + CntW'(1);
        end

        unique case (state_q)
            StIdle: begin
                cnt_d   = '0;
                armed_d = 1'b0;
                if (!line) begin
                    state_d = StStartLow;
                end
            end
            StStartLow: begin
                if (phase_done) begin
                    armed_d = 1'b1;
                end
                if (line) begin
                    cnt_d = '0;
                    if (armed_q) begin
                        frame_d = frame_in;
                        state_d = StRespDelay;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StRespDelay: begin
                if (phase_done) begin
                    cnt_d   = '0;
                    state_d = StRespLow;
                end
            end
            StRespLow: begin
                if (phase_done) begin
                    cnt_d   = '0;
                    state_d = StRespHigh;
                end
            end
            StRespHigh: begin
                if (phase_done) begin
                    cnt_d = '0;
                    if (!line) begin
                        err_d   = 1'b1;
                        state_d = StHoldoff;
                    end else begin
                        idx_d   = IdxW'(FRAME_BITS - 1);
                        state_d = StBitLow;
                    end
                end
            end
            StBitLow: begin
                if (phase_done) begin
                    cnt_d   = '0;
                    state_d = StBitHigh;
                end
            end
            StBitHigh: begin
                if (phase_done) begin
                    cnt_d = '0;
                    if (!line) begin
                        err_d   = 1'b1;
                        state_d = StHoldoff;
                    end else if (idx_q != '0) begin
                        idx_d   = idx_q - IdxW'(1);
                        frame_d = {frame_q[FRAME_BITS-2:0], 1'b0};
                        state_d = StBitLow;
                    end else begin
                        state_d = StEndLow;
                    end
                end
            end
            StEndLow: begin
                if (phase_done) begin
                    cnt_d   = '0;
                    sent_d  = 1'b1;
                    state_d = StHoldoff;
                end
            end
            StHoldoff: begin
                if (phase_done) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        drive_low = 1'b0;
        ocupado   = 1'b1;
        unique case (state_q)
            StRespLow, StBitLow, StEndLow: drive_low = 1'b1;
            default: ;
        endcase
        if ((state_q == StIdle) || (state_q == StStartLow)) begin
            ocupado = 1'b0;
        end
        // Release the bus in the same cycle reset is asserted.
        if (!reset_n) begin
            drive_low = 1'b0;
        end
    end

    assign dht_pin          = drive_low ? 1'b0 : 1'bz;
    assign quadro_enviado   = sent_q;
    assign erro_colisao     = err_q;
    assign estado_depuracao = state_q;

endmodule
